// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port register file for the pipelined core. Decode reads operands
//   and reserves destinations; writeback writes results and releases them.
//   - NRD combinational read ports, NWR posedge write ports
//   - ZERO_REG always reads 0, never stores, never becomes busy
//   - optional write-to-read bypass (BYPASS=1)
//   - per-register busy scoreboard for hazard detection
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset (clears registers and busy)
//   rd_addr_i    read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data_o    read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy_o    read port i targets a register with a pending producer
//   wr_en_i      write enable per write port
//   wr_addr_i    write addresses, port j at [j*ADDR_W +: ADDR_W]
//   wr_data_i    write data, port j at [j*DATA_W +: DATA_W]
//   mark_en_i    reserve mark_addr_i as destination of an issued instruction
//   mark_addr_i  register being reserved
//   busy_o       full scoreboard vector
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ADDR_W   = $clog2(NREGS),
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = NREGS - 1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr_i,
    output logic [NRD*DATA_W-1:0]   rd_data_o,
    output logic [NRD-1:0]          rd_busy_o,
    input  logic [NWR-1:0]          wr_en_i,
    input  logic [NWR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NWR*DATA_W-1:0]   wr_data_i,
    input  logic                    mark_en_i,
    input  logic [ADDR_W-1:0]       mark_addr_i,
    output logic [NREGS-1:0]        busy_o
);

    // One extra bit so NREGS itself is representable for the range check.
    localparam logic [ADDR_W:0]   NREGS_X = (ADDR_W + 1)'(NREGS);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [NRD-1:0]    bypass_hit;

    // Address names a real, writable register: in range and not the zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_X) && (a != ZERO_A);
    endfunction

    // Next state. Ports are walked in ascending order so the highest write
    // port wins on an address collision; the mark is applied last so a new
    // producer reserved in the same cycle as a writeback keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && addr_ok(wr_addr_i[j*ADDR_W +: ADDR_W])) begin
                regs_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = wr_data_i[j*DATA_W +: DATA_W];
                busy_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (mark_en_i && addr_ok(mark_addr_i)) begin
            busy_d[mark_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports. Invalid and zero-register addresses keep the 0 defaults, and
    // since a bypass match needs wr_addr == rd_addr, only valid writes can hit.
    always_comb begin
        rd_data_o  = '0;
        rd_busy_o  = '0;
        bypass_hit = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (addr_ok(rd_addr_i[i*ADDR_W +: ADDR_W])) begin
                rd_data_o[i*DATA_W +: DATA_W] = regs_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
                if (BYPASS) begin
                    for (int unsigned j = 0; j < NWR; j++) begin
                        if (wr_en_i[j] &&
                            (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i[i*ADDR_W +: ADDR_W])) begin
                            rd_data_o[i*DATA_W +: DATA_W] = wr_data_i[j*DATA_W +: DATA_W];
                            bypass_hit[i] = 1'b1;
                        end
                    end
                end
                rd_busy_o[i] = busy_q[rd_addr_i[i*ADDR_W +: ADDR_W]] & ~bypass_hit[i];
            end
        end
    end

    assign busy_o = busy_q;

endmodule
